// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the five-stage MIPS pipeline.
package mips_pipe_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned JT_W    = 26;
  localparam int unsigned PCSRC_W = 3;

  typedef enum logic [PCSRC_W-1:0] {
    PCSRC_SEQ   = 3'b000,
    PCSRC_BR    = 3'b001,
    PCSRC_J     = 3'b010,
    PCSRC_JR    = 3'b011,
    PCSRC_ILLOP = 3'b100,
    PCSRC_XADR  = 3'b101
  } pcsrc_e;

  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [XLEN-1:0] DEF_ILLOP_PC = 32'h8000_0004;
  localparam logic [XLEN-1:0] DEF_XADR_PC  = 32'h8000_0008;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  // Supervisor bit is sticky across increments; the low 31 bits wrap.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1], pc[XLEN-2:0] + (XLEN-1)'(4)};
  endfunction

endpackage

// File: rtl/fetch_ifid_stage_next_pc_sel.sv
// Combinational next-PC priority mux and IF/ID flush/hold decode.
module next_pc_sel
  import mips_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] ILLOP_PC = DEF_ILLOP_PC,
  parameter logic [XLEN-1:0] XADR_PC  = DEF_XADR_PC
) (
  input  logic [XLEN-1:0]    pc,
  input  logic [3:0]         ifid_pc_hi,
  input  logic               ifid_valid,
  input  logic               stall,
  input  logic [PCSRC_W-1:0] id_pcsrc,
  input  logic [JT_W-1:0]    id_jt,
  input  logic [XLEN-1:0]    id_jr_target,
  input  logic               ex_br_taken,
  input  logic [XLEN-1:0]    ex_br_target,
  output logic [XLEN-1:0]    next_pc_c,
  output logic               flush_c,
  output logic               hold_c
);

  // A stalled decode stage cannot act on its PCSrc, so stall masks it.
  always_comb begin
    next_pc_c = pc_inc(pc);
    flush_c   = 1'b0;
    hold_c    = 1'b0;
    if (ex_br_taken) begin
      next_pc_c = ex_br_target;
      flush_c   = 1'b1;
    end else if (stall) begin
      next_pc_c = pc;
      hold_c    = 1'b1;
    end else if (ifid_valid) begin
      case (id_pcsrc)
        PCSRC_ILLOP: begin
          next_pc_c = ILLOP_PC;
          flush_c   = 1'b1;
        end
        PCSRC_XADR: begin
          next_pc_c = XADR_PC;
          flush_c   = 1'b1;
        end
        PCSRC_J: begin
          next_pc_c = {ifid_pc_hi, id_jt, 2'b00};
          flush_c   = 1'b1;
        end
        PCSRC_JR: begin
          next_pc_c = id_jr_target;
          flush_c   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage: PC register, imem drive and IF/ID pipeline register.
// Optional FETCH_PERF_CNT_EN adds fetch/stall/flush performance counters.
module fetch_ifid_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [XLEN-1:0] ILLOP_PC = DEF_ILLOP_PC,
  parameter logic [XLEN-1:0] XADR_PC  = DEF_XADR_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [XLEN-1:0]    imem_data,
  input  logic               stall,
  input  logic [PCSRC_W-1:0] id_pcsrc,
  input  logic [JT_W-1:0]    id_jt,
  input  logic [XLEN-1:0]    id_jr_target,
  input  logic               ex_br_taken,
  input  logic [XLEN-1:0]    ex_br_target,
  output logic [XLEN-1:0]    ifid_instr,
  output logic [XLEN-1:0]    ifid_pc_plus4,
  output logic               ifid_valid,
  output logic               pc_sv
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0]    perf_fetch_cnt,
  output logic [XLEN-1:0]    perf_stall_cnt,
  output logic [XLEN-1:0]    perf_flush_cnt
`endif
);

  logic [XLEN-1:0] pc;
  ifid_t           ifid;
  logic [XLEN-1:0] next_pc_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic            flush_c;
  logic            hold_c;

  assign pc_plus4_c = pc_inc(pc);

  next_pc_sel #(
    .ILLOP_PC (ILLOP_PC),
    .XADR_PC  (XADR_PC)
  ) u_next_pc_sel (
    .pc           (pc),
    .ifid_pc_hi   (ifid.pc_plus4[XLEN-1 -: 4]),
    .ifid_valid   (ifid.valid),
    .stall        (stall),
    .id_pcsrc     (id_pcsrc),
    .id_jt        (id_jt),
    .id_jr_target (id_jr_target),
    .ex_br_taken  (ex_br_taken),
    .ex_br_target (ex_br_target),
    .next_pc_c    (next_pc_c),
    .flush_c      (flush_c),
    .hold_c       (hold_c)
  );

  // PC and IF/ID; a flushed slot keeps the discarded fetch's PC+4.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc   <= RESET_PC;
      ifid <= '{instr: NOP_INSTR, pc_plus4: RESET_PC, valid: 1'b0};
    end else begin
      pc <= next_pc_c;
      if (flush_c) begin
        ifid <= '{instr: NOP_INSTR, pc_plus4: pc_plus4_c, valid: 1'b0};
      end else if (!hold_c) begin
        ifid <= '{instr: imem_data, pc_plus4: pc_plus4_c, valid: 1'b1};
      end
    end
  end

  assign imem_addr     = pc;
  assign ifid_instr    = ifid.instr;
  assign ifid_pc_plus4 = ifid.pc_plus4;
  assign ifid_valid    = ifid.valid;
  assign pc_sv         = ifid.pc_plus4[XLEN-1];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!flush_c && !hold_c) perf_fetch_cnt <= perf_fetch_cnt + XLEN'(1);
      if (hold_c)              perf_stall_cnt <= perf_stall_cnt + XLEN'(1);
      if (flush_c)             perf_flush_cnt <= perf_flush_cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Scoreboard bench for fetch_ifid_stage: directed test-plan steps then random traffic.
module tb_fetch_ifid_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  id_pcsrc;
  logic [25:0] id_jt;
  logic [31:0] id_jr_target;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        pc_sv;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1234, ~a[31:16]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_ifid_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .id_pcsrc      (id_pcsrc),
    .id_jt         (id_jt),
    .id_jr_target  (id_jr_target),
    .ex_br_taken   (ex_br_taken),
    .ex_br_target  (ex_br_target),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .pc_sv         (pc_sv)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic [31:0] pf;
    logic [31:0] ps;
    logic [31:0] pfl;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: architectural view of PC, IF/ID slot and event counts.
  logic [31:0] m_pc, m_instr, m_pp4, m_pf, m_ps, m_pfl;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst_n, input logic st, input logic [2:0] src,
                      input logic [25:0] jt, input logic [31:0] jr,
                      input logic br, input logic [31:0] brt);
    logic [31:0] seq;
    logic [31:0] target;
    bit          redirect;
    exp_t        e;
    @(negedge clk);
    reset = rst_n; stall = st; id_pcsrc = src; id_jt = jt;
    id_jr_target = jr; ex_br_taken = br; ex_br_target = brt;
    seq      = {m_pc[31], m_pc[30:0] + 31'd4};
    target   = 32'h0;
    redirect = 1'b0;
    if (!rst_n) begin
      m_pc = 32'h8000_0000; m_instr = 32'h0; m_pp4 = 32'h8000_0000; m_valid = 1'b0;
      m_pf = 0; m_ps = 0; m_pfl = 0;
    end else begin
      if (br) begin
        redirect = 1'b1; target = brt;
      end else if (!st && m_valid) begin
        if (src == 3'd4)      begin redirect = 1'b1; target = 32'h8000_0004; end
        else if (src == 3'd5) begin redirect = 1'b1; target = 32'h8000_0008; end
        else if (src == 3'd2) begin redirect = 1'b1; target = {m_pp4[31:28], jt, 2'b00}; end
        else if (src == 3'd3) begin redirect = 1'b1; target = jr; end
      end
      if (redirect) begin
        m_pfl++; m_instr = 32'h0; m_valid = 1'b0; m_pp4 = seq; m_pc = target;
      end else if (st) begin
        m_ps++;
      end else begin
        m_pf++; m_instr = mem_word(m_pc); m_valid = 1'b1; m_pp4 = seq; m_pc = seq;
      end
    end
    e.addr = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid;
    e.pf = m_pf; e.ps = m_ps; e.pfl = m_pfl;
    sb.push_back(e);
  endtask

  task automatic seq_step();
    step(1'b1, 1'b0, 3'd0, 26'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: every cycle after the edge, compare DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("imem_addr", imem_addr, e.addr);
        chk("ifid_instr", ifid_instr, e.instr);
        chk("ifid_pc_plus4", ifid_pc_plus4, e.pp4);
        chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
        chk("pc_sv", 32'(pc_sv), 32'(e.pp4[31]));
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, e.pf);
        chk("perf_stall_cnt", perf_stall_cnt, e.ps);
        chk("perf_flush_cnt", perf_flush_cnt, e.pfl);
`endif
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; id_pcsrc = 3'd0; id_jt = 26'h0;
    id_jr_target = 32'h0; ex_br_taken = 1'b0; ex_br_target = 32'h0;
    step(1'b0, 1'b0, 3'd0, 26'h0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 3'd0, 26'h0, 32'h0, 1'b0, 32'h0);
    // Sequential fetch from the reset vector, then J from pc+4 0x8000_0008.
    seq_step(); seq_step();
    step(1'b1, 1'b0, 3'd2, 26'h0000040, 32'h0, 1'b0, 32'h0);
    seq_step();
    // JR into user space, then ILLOP back to the supervisor vector.
    step(1'b1, 1'b0, 3'd3, 26'h0, 32'h0000_0200, 1'b0, 32'h0);
    seq_step();
    step(1'b1, 1'b0, 3'd4, 26'h0, 32'h0, 1'b0, 32'h0);
    seq_step(); seq_step(); seq_step();
    // Two-cycle stall at 0x8000_0010 with a pending JR that must be masked.
    step(1'b1, 1'b1, 3'd3, 26'h0, 32'h0000_0300, 1'b0, 32'h0);
    step(1'b1, 1'b1, 3'd0, 26'h0, 32'h0, 1'b0, 32'h0);
    seq_step();
    // Branch beats stall and an XADR request.
    step(1'b1, 1'b1, 3'd5, 26'h0, 32'h0, 1'b1, 32'h8000_0040);
    seq_step();
    // PCSrc 001/110/111 behave as sequential.
    step(1'b1, 1'b0, 3'd1, 26'h3FFFFFF, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 3'd6, 26'h3FFFFFF, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 3'd7, 26'h3FFFFFF, 32'h0, 1'b0, 32'h0);
    // Low-31-bit wrap in both privilege modes.
    step(1'b1, 1'b0, 3'd0, 26'h0, 32'h0, 1'b1, 32'h7FFF_FFFC);
    seq_step(); seq_step();
    step(1'b1, 1'b0, 3'd0, 26'h0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    seq_step(); seq_step();
    // Reset during a JR redirect.
    step(1'b1, 1'b0, 3'd3, 26'h0, 32'h0000_0200, 1'b0, 32'h0);
    step(1'b0, 1'b0, 3'd3, 26'h0, 32'h0000_0200, 1'b0, 32'h0);
    seq_step(); seq_step();
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] jr;
      logic [31:0] brt;
      jr  = $urandom & 32'hFFFF_FFFC;
      brt = $urandom & 32'hFFFF_FFFC;
      step(($urandom % 50) != 0, ($urandom % 5) == 0, 3'($urandom % 8),
           26'($urandom), jr, ($urandom % 8) == 0, brt);
    end
    step(1'b1, 1'b0, 3'd0, 26'h0, 32'h0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
